// File: rtl/bcd_operand_sequencer.sv
`timescale 1ns/1ps
// bcd_operand_sequencer: collects a BCD operand set {A, B, Cin} from one shared
// digit switch bank, a carry switch and an asynchronous Enter pushbutton.
// Non-BCD digits are rejected at entry so the downstream adder only sees legal BCD.
//
// state  | meaning
// LOAD_A | waiting for a press to capture operand A
// LOAD_B | A held, waiting for a press to capture operand B and carry-in
// READY  | complete operand set held, valid_o high; next press starts over
// 2'b11  | unused encoding, recovers to LOAD_A on the next edge
module bcd_operand_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int DIGIT_MAX   = 9,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             digit_i,
  input  logic                   carry_in_i,
  input  logic                   enter_i,
  input  logic                   clear_i,
  output logic [3:0]             op_a_o,
  output logic [3:0]             op_b_o,
  output logic                   op_c_o,
  output logic                   valid_o,
  output logic                   error_o,
  output logic [1:0]             state_o,
  output logic [COUNT_WIDTH-1:0] op_count_o
);

  localparam logic [3:0] DIGIT_MAX_L = 4'(DIGIT_MAX);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   press;
  logic                   digit_ok;

  state_t                 state_q;
  logic [3:0]             op_a_q;
  logic [3:0]             op_b_q;
  logic                   op_c_q;
  logic                   valid_q;
  logic                   error_q;
  logic [COUNT_WIDTH-1:0] count_q;

  // Synchronise Enter and keep one cycle of history for rising-edge detection.
  // The history keeps moving during Clear, so a coincident press is consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], enter_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press    = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign digit_ok = (digit_i <= DIGIT_MAX_L);

  // Operand entry FSM; Clear outranks a press and leaves the counter alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LOAD_A;
      op_a_q  <= 4'd0;
      op_b_q  <= 4'd0;
      op_c_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else if (clear_i) begin
      state_q <= LOAD_A;
      op_a_q  <= 4'd0;
      op_b_q  <= 4'd0;
      op_c_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (press) begin
            if (digit_ok) begin
              op_a_q  <= digit_i;
              error_q <= 1'b0;
              state_q <= LOAD_B;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (press) begin
            if (digit_ok) begin
              op_b_q  <= digit_i;
              op_c_q  <= carry_in_i;
              error_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= READY;
              count_q <= count_q + COUNT_WIDTH'(1);
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        READY: begin
          if (press) begin
            valid_q <= 1'b0;
            state_q <= LOAD_A;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= LOAD_A;
        end
      endcase
    end
  end

  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;
  assign op_c_o     = op_c_q;
  assign valid_o    = valid_q;
  assign error_o    = error_q;
  assign state_o    = state_q;
  assign op_count_o = count_q;

endmodule

// File: tb/tb_bcd_operand_sequencer.sv
`timescale 1ns/1ps
// Bench for bcd_operand_sequencer: default instance plus a COUNT_WIDTH=2 instance
// driven by the same inputs, checked against a queue-based reference model.
module tb_bcd_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit;
  logic       carry;
  logic       enter;
  logic       clear;

  logic [3:0] op_a8, op_b8, op_a2, op_b2;
  logic       op_c8, valid8, err8, op_c2, valid2, err2;
  logic [1:0] state8, state2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  bcd_operand_sequencer dut (
    .clk_i(clk), .rst_i(rst), .digit_i(digit), .carry_in_i(carry),
    .enter_i(enter), .clear_i(clear),
    .op_a_o(op_a8), .op_b_o(op_b8), .op_c_o(op_c8), .valid_o(valid8),
    .error_o(err8), .state_o(state8), .op_count_o(cnt8)
  );

  bcd_operand_sequencer #(.COUNT_WIDTH(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .digit_i(digit), .carry_in_i(carry),
    .enter_i(enter), .clear_i(clear),
    .op_a_o(op_a2), .op_b_o(op_b2), .op_c_o(op_c2), .valid_o(valid2),
    .error_o(err2), .state_o(state2), .op_count_o(cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0/1/2 = waiting for A / waiting for B / set complete.
  int m_phase, m_a, m_b, m_c, m_err, m_cnt;
  bit samp_q[$];

  function automatic void model_reset();
    m_phase = 0; m_a = 0; m_b = 0; m_c = 0; m_err = 0; m_cnt = 0;
    samp_q.delete();
    repeat (3) samp_q.push_back(1'b0);
  endfunction

  // One rising edge: a press acts when Enter was sampled high two edges ago
  // and low three edges ago.
  function automatic void model_edge();
    bit pr;
    samp_q.push_back(enter);
    pr = samp_q[$-2] && !samp_q[$-3];
    while (samp_q.size() > 6) void'(samp_q.pop_front());
    if (clear) begin
      m_phase = 0; m_a = 0; m_b = 0; m_c = 0; m_err = 0;
    end else if (pr) begin
      if (m_phase == 0) begin
        if (digit > 9) m_err = 1;
        else begin m_a = digit; m_err = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (digit > 9) m_err = 1;
        else begin m_b = digit; m_c = carry; m_err = 0; m_phase = 2; m_cnt++; end
      end else begin
        m_phase = 0;
      end
    end
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] exp8, exp2;
    exp8 = {11'd0, 2'(m_phase), 4'(m_a), 4'(m_b), 1'(m_c), (m_phase == 2), 1'(m_err), 8'(m_cnt % 256)};
    exp2 = {17'd0, 2'(m_phase), 4'(m_a), 4'(m_b), 1'(m_c), (m_phase == 2), 1'(m_err), 2'(m_cnt % 4)};
    cmp("model_w8", {11'd0, state8, op_a8, op_b8, op_c8, valid8, err8, cnt8}, exp8);
    cmp("model_w2", {17'd0, state2, op_a2, op_b2, op_c2, valid2, err2, cnt2}, exp2);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic press(input logic [3:0] d, input logic c);
    digit = d; carry = c; enter = 1'b1;
    repeat (3) cycle();
    enter = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic [3:0] d;
    logic       c;
    logic [1:0] st;
    logic [3:0] a;
    logic [3:0] b;
    logic       oc;
    logic       v;
    logic       e;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[8];
  int   seq_w2[5];

  initial begin
    // Starts in LOAD_B with A=7 after the hand-timed first capture.
    tbl[0] = '{d: 4'd5,  c: 1'b1, st: 2'b10, a: 4'd7, b: 4'd5, oc: 1'b1, v: 1'b1, e: 1'b0, cnt: 8'd1};
    tbl[1] = '{d: 4'd12, c: 1'b0, st: 2'b00, a: 4'd7, b: 4'd5, oc: 1'b1, v: 1'b0, e: 1'b0, cnt: 8'd1};
    tbl[2] = '{d: 4'd12, c: 1'b0, st: 2'b00, a: 4'd7, b: 4'd5, oc: 1'b1, v: 1'b0, e: 1'b1, cnt: 8'd1};
    tbl[3] = '{d: 4'd9,  c: 1'b0, st: 2'b01, a: 4'd9, b: 4'd5, oc: 1'b1, v: 1'b0, e: 1'b0, cnt: 8'd1};
    tbl[4] = '{d: 4'd10, c: 1'b1, st: 2'b01, a: 4'd9, b: 4'd5, oc: 1'b1, v: 1'b0, e: 1'b1, cnt: 8'd1};
    tbl[5] = '{d: 4'd15, c: 1'b1, st: 2'b01, a: 4'd9, b: 4'd5, oc: 1'b1, v: 1'b0, e: 1'b1, cnt: 8'd1};
    tbl[6] = '{d: 4'd0,  c: 1'b0, st: 2'b10, a: 4'd9, b: 4'd0, oc: 1'b0, v: 1'b1, e: 1'b0, cnt: 8'd2};
    tbl[7] = '{d: 4'd15, c: 1'b1, st: 2'b00, a: 4'd9, b: 4'd0, oc: 1'b0, v: 1'b0, e: 1'b0, cnt: 8'd2};
    seq_w2 = '{1, 2, 3, 0, 1};

    rst = 1'b1; digit = 4'd0; carry = 1'b0; enter = 1'b0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_state", 32'(state8), 32'd0);
    cmp("reset_op_a", 32'(op_a8), 32'd0);
    cmp("reset_valid", 32'(valid8), 32'd0);
    cmp("reset_error", 32'(err8), 32'd0);
    cmp("reset_count", 32'(cnt8), 32'd0);
    rst = 1'b0;
    cycle();

    // Capture lands on the third edge after Enter rises.
    digit = 4'd7; enter = 1'b1;
    cycle(); cmp("t1_edge1_state", 32'(state8), 32'd0);
    cycle(); cmp("t1_edge2_state", 32'(state8), 32'd0);
    cycle(); cmp("t1_edge3_state", 32'(state8), 32'd1);
    cmp("t1_edge3_op_a", 32'(op_a8), 32'd7);
    enter = 1'b0;
    cycle();

    for (int i = 0; i < 8; i++) begin
      press(tbl[i].d, tbl[i].c);
      cmp($sformatf("tbl%0d_state", i), 32'(state8), 32'(tbl[i].st));
      cmp($sformatf("tbl%0d_op_a", i), 32'(op_a8), 32'(tbl[i].a));
      cmp($sformatf("tbl%0d_op_b", i), 32'(op_b8), 32'(tbl[i].b));
      cmp($sformatf("tbl%0d_op_c", i), 32'(op_c8), 32'(tbl[i].oc));
      cmp($sformatf("tbl%0d_valid", i), 32'(valid8), 32'(tbl[i].v));
      cmp($sformatf("tbl%0d_error", i), 32'(err8), 32'(tbl[i].e));
      cmp($sformatf("tbl%0d_count", i), 32'(cnt8), 32'(tbl[i].cnt));
    end

    // Held Enter gives exactly one capture.
    digit = 4'd3; enter = 1'b1;
    repeat (20) cycle();
    cmp("hold_state", 32'(state8), 32'd1);
    cmp("hold_op_a", 32'(op_a8), 32'd3);
    enter = 1'b0;
    cycle();

    // Clear coincident with a press in LOAD_B: press consumed, counter kept.
    digit = 4'd4; enter = 1'b1;
    cycle(); cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cmp("clr_state", 32'(state8), 32'd0);
    cmp("clr_op_a", 32'(op_a8), 32'd0);
    cmp("clr_op_b", 32'(op_b8), 32'd0);
    cmp("clr_valid", 32'(valid8), 32'd0);
    cmp("clr_count", 32'(cnt8), 32'd2);
    enter = 1'b0;
    repeat (4) cycle();
    cmp("clr_no_deferred", 32'(state8), 32'd0);

    // Asynchronous reset mid-entry.
    press(4'd6, 1'b0);
    cmp("prerst_op_a", 32'(op_a8), 32'd6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    cmp("arst_state", 32'(state8), 32'd0);
    cmp("arst_op_a", 32'(op_a8), 32'd0);
    cmp("arst_count", 32'(cnt8), 32'd0);
    check_model();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Counter wrap on the narrow instance and Valid drop on a READY press.
    for (int i = 0; i < 5; i++) begin
      press(4'(i + 1), 1'b0);
      press(4'(i), 1'b1);
      cmp($sformatf("wrap%0d_count_w2", i), 32'(cnt2), 32'(seq_w2[i]));
      cmp($sformatf("wrap%0d_count_w8", i), 32'(cnt8), 32'(i + 1));
      enter = 1'b1;
      cycle(); cycle();
      cmp($sformatf("wrap%0d_valid_held", i), 32'(valid2), 32'd1);
      cycle();
      cmp($sformatf("wrap%0d_valid_drop", i), 32'(valid2), 32'd0);
      cmp($sformatf("wrap%0d_state_drop", i), 32'(state2), 32'd0);
      enter = 1'b0;
      cycle();
    end

    // Random stimulus against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) enter = ~enter;
      digit = 4'($urandom_range(0, 15));
      carry = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 24) == 0);
      cycle();
    end
    clear = 1'b0;
    enter = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
